// File: rtl/uctl_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// uctl_frame_scheduler_if
// Handshake bundle between the frame scheduler and its neighbours:
//   req          endpoint transfer requests (level, held until granted)
//   gnt          one-hot grant, held for the whole transfer
//   tx_start     1-cycle start pulse to the packet transmitter
//   tx_is_sof    qualifies the current start/transfer as an SOF token
//   tx_sof_frame frame number carried by the SOF token
//   tx_done      1-cycle completion pulse from the transmitter
// master: scheduler side.  slave: endpoints + transmitter side.
// ----------------------------------------------------------------------------
interface uctl_frame_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int FRM_WD  = 11
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               tx_start;
    logic               tx_is_sof;
    logic [FRM_WD-1:0]  tx_sof_frame;
    logic               tx_done;

    modport master (
        input  req,
        input  tx_done,
        output gnt,
        output tx_start,
        output tx_is_sof,
        output tx_sof_frame
    );

    modport slave (
        output req,
        output tx_done,
        input  gnt,
        input  tx_start,
        input  tx_is_sof,
        input  tx_sof_frame
    );
endinterface

// File: rtl/uctl_frame_scheduler.sv
// ----------------------------------------------------------------------------
// uctl_frame_scheduler
// Frame-level transmit scheduler: issues one SOF token per frame boundary
// (when auto-SOF is enabled), round-robin arbitrates endpoint requests onto
// the shared transmitter, and blocks new transfers inside the EOF1 window.
// Ports:
//   clk, phy_rst_n   clock, async active-low reset
//   sw_rst_i         synchronous reset, same effect as phy_rst_n
//   frm_bndry_i      frame-boundary pulse, frame_num_i valid with it
//   eof1_hit_i       EOF1 point of the current frame reached
//   en_auto_sof_i    enable SOF generation
//   bus              request/grant/transmitter handshake (master side)
//   sof_sent_o       pulse on completion of an SOF
//   babble_err_o     pulse: frame boundary during an endpoint transfer
//   sof_miss_cnt_o   saturating count of SOFs overwritten before being sent
// ----------------------------------------------------------------------------
module uctl_frame_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int FRM_WD  = 11,
    parameter int MISS_WD = 8
) (
    input  logic               clk,
    input  logic               phy_rst_n,
    input  logic               sw_rst_i,
    input  logic               frm_bndry_i,
    input  logic [FRM_WD-1:0]  frame_num_i,
    input  logic               eof1_hit_i,
    input  logic               en_auto_sof_i,
    uctl_frame_scheduler_if.master bus,
    output logic               sof_sent_o,
    output logic               babble_err_o,
    output logic [MISS_WD-1:0] sof_miss_cnt_o
);

    localparam int PTR_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOF_WAIT  = 2'd1,
        XFER_WAIT = 2'd2
    } state_e;

    state_e             state_q;
    logic [PTR_WD-1:0]  rr_q;
    logic [PTR_WD-1:0]  win_q;
    logic               sof_pend_q;
    logic               eof_win_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               tx_start_q;
    logic               tx_is_sof_q;
    logic [FRM_WD-1:0]  frame_q;
    logic               sof_sent_q;
    logic               babble_q;
    logic [MISS_WD-1:0] miss_q;

    logic               win_found;
    logic [PTR_WD-1:0]  win_idx_d;
    logic [PTR_WD:0]    cand_sum;
    logic [PTR_WD-1:0]  rr_d;

    // Circular search starting at the round-robin pointer; the extra sum bit
    // handles the wrap for non-power-of-two requester counts.
    always_comb begin
        win_found = 1'b0;
        win_idx_d = '0;
        cand_sum  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_q} + (PTR_WD+1)'(i);
            if (cand_sum >= (PTR_WD+1)'(NUM_REQ))
                cand_sum = cand_sum - (PTR_WD+1)'(NUM_REQ);
            if (!win_found && bus.req[cand_sum[PTR_WD-1:0]]) begin
                win_found = 1'b1;
                win_idx_d = cand_sum[PTR_WD-1:0];
            end
        end
    end

    assign rr_d = (win_q == PTR_WD'(NUM_REQ-1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            sof_pend_q  <= 1'b0;
            eof_win_q   <= 1'b0;
            gnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_is_sof_q <= 1'b0;
            frame_q     <= '0;
            sof_sent_q  <= 1'b0;
            babble_q    <= 1'b0;
            miss_q      <= '0;
        end else if (sw_rst_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            sof_pend_q  <= 1'b0;
            eof_win_q   <= 1'b0;
            gnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_is_sof_q <= 1'b0;
            frame_q     <= '0;
            sof_sent_q  <= 1'b0;
            babble_q    <= 1'b0;
            miss_q      <= '0;
        end else begin
            tx_start_q <= 1'b0;
            sof_sent_q <= 1'b0;
            babble_q   <= 1'b0;

            // Boundary closes the window even if EOF1 fires in the same cycle.
            if (frm_bndry_i)
                eof_win_q <= 1'b0;
            else if (eof1_hit_i)
                eof_win_q <= 1'b1;

            // A boundary with an SOF still pending drops the older SOF; the
            // newest frame number replaces it.
            if (frm_bndry_i && sof_pend_q && (miss_q != '1))
                miss_q <= miss_q + 1'b1;
            if (frm_bndry_i && (en_auto_sof_i || sof_pend_q))
                frame_q <= frame_num_i;

            case (state_q)
                IDLE: begin
                    if (sof_pend_q) begin
                        state_q     <= SOF_WAIT;
                        sof_pend_q  <= 1'b0;
                        tx_start_q  <= 1'b1;
                        tx_is_sof_q <= 1'b1;
                    end else if (win_found && !eof_win_q) begin
                        state_q    <= XFER_WAIT;
                        win_q      <= win_idx_d;
                        gnt_q      <= NUM_REQ'(1) << win_idx_d;
                        tx_start_q <= 1'b1;
                    end
                end
                SOF_WAIT: begin
                    if (bus.tx_done) begin
                        state_q     <= IDLE;
                        tx_is_sof_q <= 1'b0;
                        sof_sent_q  <= 1'b1;
                    end
                end
                XFER_WAIT: begin
                    if (frm_bndry_i)
                        babble_q <= 1'b1;
                    if (bus.tx_done) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        rr_q    <= rr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Placed after the FSM so a new boundary outranks the clear on
            // SOF_WAIT entry.
            if (frm_bndry_i && en_auto_sof_i)
                sof_pend_q <= 1'b1;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_is_sof    = tx_is_sof_q;
    assign bus.tx_sof_frame = frame_q;
    assign sof_sent_o       = sof_sent_q;
    assign babble_err_o     = babble_q;
    assign sof_miss_cnt_o   = miss_q;

endmodule

// File: tb/tb_uctl_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uctl_frame_scheduler
// Directed bench for the frame scheduler. Every expected transmitter start
// (SOF with frame number, or endpoint grant) is queued when the stimulus
// that causes it is driven, and popped when tx_start appears.
// ----------------------------------------------------------------------------
module tb_uctl_frame_scheduler;

    typedef struct packed {
        logic        is_sof;
        logic [10:0] frame;
        logic [3:0]  gnt;
    } exp_t;

    logic        clk;
    logic        phy_rst_n;
    logic        sw_rst_i;
    logic        frm_bndry_i;
    logic [10:0] frame_num_i;
    logic        eof1_hit_i;
    logic        en_auto_sof_i;
    logic        sof_sent_o;
    logic        babble_err_o;
    logic [7:0]  sof_miss_cnt_o;

    int   total;
    int   bad;
    int   n;
    logic stray;
    exp_t exp_q[$];

    uctl_frame_scheduler_if #(.NUM_REQ(4), .FRM_WD(11)) bus ();

    uctl_frame_scheduler #(.NUM_REQ(4), .FRM_WD(11), .MISS_WD(8)) dut (
        .clk            (clk),
        .phy_rst_n      (phy_rst_n),
        .sw_rst_i       (sw_rst_i),
        .frm_bndry_i    (frm_bndry_i),
        .frame_num_i    (frame_num_i),
        .eof1_hit_i     (eof1_hit_i),
        .en_auto_sof_i  (en_auto_sof_i),
        .bus            (bus),
        .sof_sent_o     (sof_sent_o),
        .babble_err_o   (babble_err_o),
        .sof_miss_cnt_o (sof_miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_sof(input logic [10:0] f);
        exp_t e;
        e.is_sof = 1'b1; e.frame = f; e.gnt = 4'b0000;
        exp_q.push_back(e);
    endtask

    task automatic push_gnt(input logic [3:0] g);
        exp_t e;
        e.is_sof = 1'b0; e.frame = '0; e.gnt = g;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for tx_start and compares it with the oldest expectation.
    task automatic wait_start(input string tag, input int max, output int cyc);
        exp_t e;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.tx_start && cyc < max);
        if (!bus.tx_start) begin
            chk({tag, "_timeout"}, 32'(cyc), 32'(max + 1));
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_start"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_is_sof"}, 32'(bus.tx_is_sof), 32'(e.is_sof));
            chk({tag, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
            if (e.is_sof)
                chk({tag, "_frame"}, 32'(bus.tx_sof_frame), 32'(e.frame));
        end
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic bndry(input logic [10:0] f);
        frm_bndry_i = 1'b1;
        frame_num_i = f;
        tick();
        frm_bndry_i = 1'b0;
    endtask

    initial begin
        logic [3:0] order [5];
        total = 0;
        bad   = 0;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        phy_rst_n     = 1'b0;
        sw_rst_i      = 1'b0;
        frm_bndry_i   = 1'b0;
        frame_num_i   = '0;
        eof1_hit_i    = 1'b0;
        en_auto_sof_i = 1'b0;
        bus.req       = '0;
        bus.tx_done   = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_is_sof", 32'(bus.tx_is_sof), 32'd0);
        chk("rst_frame", 32'(bus.tx_sof_frame), 32'd0);
        chk("rst_miss", 32'(sof_miss_cnt_o), 32'd0);
        chk("rst_pulses", 32'({sof_sent_o, babble_err_o}), 32'd0);
        phy_rst_n     = 1'b1;
        en_auto_sof_i = 1'b1;
        tick();

        // 1: single SOF, two cycles after the boundary
        push_sof(11'h123);
        bndry(11'h123);
        wait_start("t1_sof", 8, n);
        chk("t1_latency", 32'(n + 1), 32'd2);
        tick();
        chk("t1_is_sof_held", 32'(bus.tx_is_sof), 32'd1);
        pulse_done();
        chk("t1_sof_sent", 32'(sof_sent_o), 32'd1);
        chk("t1_is_sof_clr", 32'(bus.tx_is_sof), 32'd0);
        tick();
        chk("t1_sof_sent_pulse", 32'(sof_sent_o), 32'd0);

        // 2: all requesting, round-robin order
        for (int k = 0; k < 5; k++) push_gnt(order[k]);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start("t2_xfer", 8, n);
            chk("t2_latency", 32'(n), 32'd1);
            tick();
            tick();
            if (k == 4) bus.req = 4'b0000;
            pulse_done();
            chk("t2_gnt_release", 32'(bus.gnt), 32'd0);
        end

        // 3: SOF beats a request arriving together with sof_pend
        push_sof(11'h0AA);
        push_gnt(4'b0010);
        bndry(11'h0AA);
        bus.req = 4'b0010;
        wait_start("t3_sof", 8, n);
        tick();
        pulse_done();
        chk("t3_sof_sent", 32'(sof_sent_o), 32'd1);
        wait_start("t3_xfer", 8, n);
        bus.req = 4'b0000;
        tick();
        chk("t3_gnt_held", 32'(bus.gnt), 32'b0010);
        pulse_done();

        // 4: EOF1 window blocks requests until the next boundary
        eof1_hit_i = 1'b1;
        tick();
        eof1_hit_i = 1'b0;
        bus.req = 4'b0001;
        stray = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.tx_start || bus.gnt != 4'b0000) stray = 1'b1;
        end
        chk("t4_eof_block", 32'(stray), 32'd0);
        push_sof(11'h7FF);
        push_gnt(4'b0001);
        bndry(11'h7FF);
        wait_start("t4_sof", 8, n);
        pulse_done();
        wait_start("t4_xfer", 8, n);
        bus.req = 4'b0000;
        tick();
        pulse_done();

        // 5: boundary during an endpoint transfer -> babble, SOF after done
        push_gnt(4'b0100);
        bus.req = 4'b0100;
        wait_start("t5_xfer", 8, n);
        tick();
        push_sof(11'h055);
        bndry(11'h055);
        chk("t5_babble", 32'(babble_err_o), 32'd1);
        tick();
        chk("t5_babble_pulse", 32'(babble_err_o), 32'd0);
        chk("t5_not_aborted", 32'(bus.gnt), 32'b0100);
        chk("t5_miss", 32'(sof_miss_cnt_o), 32'd0);
        bus.req = 4'b0000;
        pulse_done();
        wait_start("t5_sof", 8, n);
        chk("t5_sof_latency", 32'(n), 32'd1);
        pulse_done();

        // 5b: boundary and tx_done together in XFER_WAIT
        push_gnt(4'b1000);
        bus.req = 4'b1000;
        wait_start("t5b_xfer", 8, n);
        bus.req = 4'b0000;
        tick();
        push_sof(11'h3C3);
        frm_bndry_i = 1'b1;
        frame_num_i = 11'h3C3;
        bus.tx_done = 1'b1;
        tick();
        frm_bndry_i = 1'b0;
        bus.tx_done = 1'b0;
        chk("t5b_babble", 32'(babble_err_o), 32'd1);
        chk("t5b_gnt_release", 32'(bus.gnt), 32'd0);
        wait_start("t5b_sof", 8, n);
        pulse_done();

        // 6: boundaries while SOF_WAIT is stalled
        push_sof(11'd4);
        bndry(11'd4);
        wait_start("t6_sof4", 8, n);
        bndry(11'd5);
        bndry(11'd6);
        chk("t6_miss_one", 32'(sof_miss_cnt_o), 32'd1);
        push_sof(11'd6);
        pulse_done();
        wait_start("t6_sof6", 8, n);
        frm_bndry_i = 1'b1;
        frame_num_i = 11'd100;
        for (int k = 0; k < 300; k++) tick();
        frm_bndry_i = 1'b0;
        chk("t6_miss_sat", 32'(sof_miss_cnt_o), 32'd255);

        // 7: sync reset discards the pending SOF and clears outputs
        sw_rst_i = 1'b1;
        tick();
        sw_rst_i = 1'b0;
        chk("t7_is_sof", 32'(bus.tx_is_sof), 32'd0);
        chk("t7_miss", 32'(sof_miss_cnt_o), 32'd0);
        chk("t7_frame", 32'(bus.tx_sof_frame), 32'd0);
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.tx_start) stray = 1'b1;
        end
        chk("t7_pend_dropped", 32'(stray), 32'd0);

        // 8: async reset mid-transfer, pointer back at 0 so requester 3 wins
        push_gnt(4'b1000);
        bus.req = 4'b1000;
        wait_start("t8_xfer", 8, n);
        #2 phy_rst_n = 1'b0;
        #1;
        chk("t8_async_gnt", 32'(bus.gnt), 32'd0);
        chk("t8_async_start", 32'(bus.tx_start), 32'd0);
        bus.req = 4'b0000;
        tick();
        phy_rst_n = 1'b1;
        tick();
        tick();
        chk("t8_idle_after", 32'({bus.tx_start, bus.gnt}), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
